// File: rtl/inst_fetcher_pkg.sv
// Shared widths, opcodes and types for the instruction fetch front end.
// Imported by the fetcher, its queue and the bus interface.
package inst_fetcher_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] EMPTY_INST = '0;
  localparam logic [6:0]            OP_LOAD    = 7'b0000011;
  localparam logic [6:0]            OP_STORE   = 7'b0100011;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_DISCARD  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
  } queue_entry_t;

  function automatic logic is_load_store(input logic [INST_WIDTH-1:0] inst);
    return (inst[6:0] == OP_LOAD) || (inst[6:0] == OP_STORE);
  endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Fetcher-side bus bundle: memory fetch port, ROB redirect and decoder handoff.
// master = fetcher view, slave = surrounding pipeline view.
interface inst_fetcher_if;
  import inst_fetcher_pkg::*;

  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [INST_WIDTH-1:0] mem_inst;
  logic                  rob_redirect;
  logic [ADDR_WIDTH-1:0] rob_redirect_pc;
  logic                  dec_ready;
  logic                  inst_valid;
  logic [INST_WIDTH-1:0] inst_to_dec;
  logic [ADDR_WIDTH-1:0] pc_to_dec;
  logic                  if_ls;

  modport master (
    output mem_req, mem_addr, inst_valid, inst_to_dec, pc_to_dec, if_ls,
    input  mem_ack, mem_inst, rob_redirect, rob_redirect_pc, dec_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst_to_dec, pc_to_dec, if_ls,
    output mem_ack, mem_inst, rob_redirect, rob_redirect_pc, dec_ready
  );

endinterface

// File: rtl/inst_fetcher_queue.sv
// In-order circular queue of {inst, pc} with flush; head is read combinationally.
// Callers never push into a full queue, so no overflow guard is needed here.
module inst_fetcher_queue
  import inst_fetcher_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         i_flush,
  input  logic         i_push,
  input  queue_entry_t i_push_entry,
  input  logic         i_pop,
  output logic         o_valid,
  output queue_entry_t o_head_entry,
  output logic [PTR_W:0] o_count
);

  queue_entry_t   r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             w_do_pop;

  assign w_do_pop = i_pop && (r_count != '0);

  // Pointers wrap naturally because DEPTH == 2**PTR_W.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push)   r_tail <= r_tail + PTR_W'(1);
      if (w_do_pop) r_head <= r_head + PTR_W'(1);
      if (i_push && !w_do_pop)      r_count <= r_count + (PTR_W+1)'(1);
      else if (!i_push && w_do_pop) r_count <= r_count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (i_push && !i_flush) r_mem[r_tail] <= i_push_entry;
  end

  assign o_valid      = (r_count != '0);
  assign o_head_entry = r_mem[r_head];
  assign o_count      = r_count;

endmodule

// File: rtl/inst_fetcher.sv
// Front-end fetch stage: one outstanding memory fetch at a time, in-order queue
// toward the decoder, and flush/restart on ROB redirect.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int                    QUEUE_DEPTH = 8,
  parameter int                    PTR_WIDTH   = 3,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h0
) (
  input  logic          clk_in,
  input  logic          rst_in,
  inst_fetcher_if.master bus
);

  fetch_state_t          r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_req;

  logic                  w_q_valid;
  queue_entry_t          w_head;
  logic [PTR_WIDTH:0]    w_count;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_has_space;
  queue_entry_t          w_push_entry;

  // Enqueue only lands on the ack edge, so in IDLE the count is already final.
  assign w_has_space  = (w_count < (PTR_WIDTH+1)'(QUEUE_DEPTH));
  assign w_push       = (r_state == ST_WAIT_MEM) && bus.mem_ack && !bus.rob_redirect;
  assign w_pop        = w_q_valid && bus.dec_ready;
  assign w_push_entry = '{inst: bus.mem_inst, pc: r_mem_addr};

  inst_fetcher_queue #(
    .DEPTH (QUEUE_DEPTH),
    .PTR_W (PTR_WIDTH)
  ) u_queue (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .i_flush      (bus.rob_redirect),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_valid      (w_q_valid),
    .o_head_entry (w_head),
    .o_count      (w_count)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_mem_addr <= RESET_PC;
      r_mem_req  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.rob_redirect) begin
            r_pc <= bus.rob_redirect_pc;
          end else if (w_has_space) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_pc;
            r_state    <= ST_WAIT_MEM;
          end
        end
        ST_WAIT_MEM: begin
          if (bus.rob_redirect) begin
            r_pc <= bus.rob_redirect_pc;
            if (bus.mem_ack) begin
              r_mem_req <= 1'b0;
              r_state   <= ST_IDLE;
            end else begin
              r_state <= ST_DISCARD;
            end
          end else if (bus.mem_ack) begin
            r_pc      <= r_pc + ADDR_WIDTH'(4);
            r_mem_req <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        ST_DISCARD: begin
          // Memory cannot cancel: keep the stale request up until its ack, then drop it.
          if (bus.rob_redirect) r_pc <= bus.rob_redirect_pc;
          if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.inst_valid  = w_q_valid;
  assign bus.inst_to_dec = w_q_valid ? w_head.inst : '0;
  assign bus.pc_to_dec   = w_q_valid ? w_head.pc : EMPTY_INST;
  assign bus.if_ls       = w_q_valid && is_load_store(w_head.inst);

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: transaction-level queue model plus a
// latency-configurable memory responder, directed scenarios then random traffic.
module tb_inst_fetcher;

  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_fetcher_if bus();

  inst_fetcher #(
    .QUEUE_DEPTH (DEPTH),
    .PTR_WIDTH   (3),
    .RESET_PC    (32'h0)
  ) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } item_t;

  int          checks = 0;
  int          errors = 0;
  item_t       exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] exp_next;
  logic [31:0] mem_over [logic [31:0]];
  bit          busy;
  bit          discard;
  logic [31:0] cur_addr;
  int          countdown;
  int          lat_lo = 2;
  int          lat_hi = 2;
  int          delivered = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    logic [6:0]  op;
    if (mem_over.exists(a)) return mem_over[a];
    h = (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    case (h[9:8])
      2'd0:    op = 7'b0000011;
      2'd1:    op = 7'b0100011;
      2'd2:    op = 7'b0010011;
      default: op = 7'b0110011;
    endcase
    return {h[31:7], op};
  endfunction

  function automatic logic exp_ls(input logic [31:0] inst);
    logic [6:0] op;
    op = inst[6:0];
    return (op == 7'b0000011) || (op == 7'b0100011);
  endfunction

  // One clock: check decoder outputs, advance model across the edge, then respond as memory.
  task automatic cycle();
    bit          redir;
    bit          ack;
    bit          deq;
    logic [31:0] redir_pc;
    logic [31:0] ack_data;
    if (exp_q.size() != 0) begin
      chk("head_inst", bus.inst_to_dec, exp_q[0].inst);
      chk("head_pc", bus.pc_to_dec, exp_q[0].pc);
      chk("head_ls", bus.if_ls, exp_ls(exp_q[0].inst));
    end else begin
      chk("empty_inst", bus.inst_to_dec, 32'h0);
      chk("empty_pc", bus.pc_to_dec, 32'h0);
      chk("empty_ls", bus.if_ls, 32'h0);
    end
    redir    = bus.rob_redirect;
    redir_pc = bus.rob_redirect_pc;
    ack      = bus.mem_ack && busy;
    ack_data = bus.mem_inst;
    deq      = (exp_q.size() != 0) && bus.dec_ready && !redir;
    @(posedge clk);
    #1;
    if (redir) begin
      exp_q.delete();
      exp_next = redir_pc;
      if (busy && !ack) discard = 1'b1;
    end else begin
      if (deq) begin
        exp_q.delete(0);
        delivered++;
      end
      if (ack && !discard) begin
        exp_q.push_back('{inst: ack_data, pc: cur_addr});
        exp_next = cur_addr + 32'd4;
      end
    end
    if (ack) begin
      busy    = 1'b0;
      discard = 1'b0;
    end
    chk("valid", bus.inst_valid, (exp_q.size() != 0) ? 32'd1 : 32'd0);
    if (busy) begin
      chk("req_held", bus.mem_req, 32'd1);
      chk("addr_stable", bus.mem_addr, cur_addr);
    end else if (ack) begin
      chk("req_drop", bus.mem_req, 32'd0);
    end else if (bus.mem_req === 1'b1) begin
      chk("req_addr", bus.mem_addr, exp_next);
      chk("req_space", (exp_q.size() < DEPTH) ? 32'd1 : 32'd0, 32'd1);
      busy      = 1'b1;
      cur_addr  = exp_next;
      req_log.push_back(bus.mem_addr);
      countdown = $urandom_range(lat_hi, lat_lo);
    end
    bus.mem_ack      = 1'b0;
    bus.rob_redirect = 1'b0;
    if (busy) begin
      countdown--;
      if (countdown <= 0) begin
        bus.mem_ack  = 1'b1;
        bus.mem_inst = mem_word(cur_addr);
      end
    end
  endtask

  // Asserts reset mid-cycle, checks outputs while it is low, releases just after an edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_req", bus.mem_req, 32'd0);
    chk("rst_valid", bus.inst_valid, 32'd0);
    chk("rst_inst", bus.inst_to_dec, 32'h0);
    chk("rst_pc", bus.pc_to_dec, 32'h0);
    chk("rst_ls", bus.if_ls, 32'd0);
    exp_q.delete();
    req_log.delete();
    busy     = 1'b0;
    discard  = 1'b0;
    exp_next = 32'h0;
    bus.mem_ack         = 1'b0;
    bus.mem_inst        = 32'h0;
    bus.rob_redirect    = 1'b0;
    bus.rob_redirect_pc = 32'h0;
    bus.dec_ready       = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] t1_pc[$];
    logic [31:0] t1_ls[$];
    logic [31:0] rnd;
    logic [31:0] bad_addr;
    bit          seen_bad;
    int          d0;

    bus.mem_ack         = 1'b0;
    bus.mem_inst        = 32'h0;
    bus.rob_redirect    = 1'b0;
    bus.rob_redirect_pc = 32'h0;
    bus.dec_ready       = 1'b0;
    @(posedge clk);
    #1;

    // Basic two-fetch flow with one load/store instruction
    mem_over[32'h0] = 32'h00000013;
    mem_over[32'h4] = 32'h00112023;
    lat_lo = 2; lat_hi = 2;
    do_reset();
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (bus.inst_valid === 1'b1) begin
        t1_pc.push_back(bus.pc_to_dec);
        t1_ls.push_back({31'h0, bus.if_ls});
      end
      cycle();
    end
    chk("t1_req0", req_log[0], 32'h0);
    chk("t1_req1", req_log[1], 32'h4);
    chk("t1_dec_pc0", t1_pc[0], 32'h0);
    chk("t1_dec_ls0", t1_ls[0], 32'd0);
    chk("t1_dec_pc1", t1_pc[1], 32'h4);
    chk("t1_dec_ls1", t1_ls[1], 32'd1);

    // Decoder stalled: exactly DEPTH fetches, then one more after a single dequeue
    lat_lo = 1; lat_hi = 1;
    do_reset();
    for (int i = 0; i < 40; i++) cycle();
    chk("t2_nreq", req_log.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) chk("t2_addr", req_log[i], 32'(i * 4));
    chk("t2_req_low", bus.mem_req, 32'd0);
    bus.dec_ready = 1'b1;
    cycle();
    bus.dec_ready = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    chk("t2_nreq_after", req_log.size(), DEPTH + 1);
    chk("t2_addr_after", req_log[DEPTH], 32'h20);

    // Redirect while a fetch is outstanding; its data must be discarded
    lat_lo = 3; lat_hi = 3;
    do_reset();
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 100 && req_log.size() < 3; i++) cycle();
    chk("t3_reached", (req_log.size() >= 3 && busy) ? 32'd1 : 32'd0, 32'd1);
    bad_addr = cur_addr;
    mem_over[bad_addr] = 32'hDEADBEEF;
    bus.rob_redirect    = 1'b1;
    bus.rob_redirect_pc = 32'h100;
    cycle();
    chk("t3_flushed", bus.inst_valid, 32'd0);
    seen_bad = 1'b0;
    for (int i = 0; i < 30 && req_log.size() < 4; i++) begin
      cycle();
      if (bus.inst_valid === 1'b1 && bus.inst_to_dec === 32'hDEADBEEF) seen_bad = 1'b1;
    end
    chk("t3_no_stale", seen_bad, 32'd0);
    chk("t3_next_addr", req_log[3], 32'h100);
    mem_over.delete(bad_addr);

    // Redirect coinciding with mem_ack and a decoder dequeue
    lat_lo = 2; lat_hi = 2;
    do_reset();
    for (int i = 0; i < 50 && !(bus.mem_ack === 1'b1 && exp_q.size() != 0); i++) cycle();
    chk("t4_reached", (bus.mem_ack === 1'b1 && exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
    bus.dec_ready       = 1'b1;
    bus.rob_redirect    = 1'b1;
    bus.rob_redirect_pc = 32'h200;
    cycle();
    chk("t4_empty", bus.inst_valid, 32'd0);
    chk("t4_req_idle", bus.mem_req, 32'd0);
    cycle();
    chk("t4_req", bus.mem_req, 32'd1);
    chk("t4_addr", bus.mem_addr, 32'h200);

    // Reset with a nearly full queue and a fetch outstanding, then a stray ack
    lat_lo = 3; lat_hi = 5;
    do_reset();
    for (int i = 0; i < 200 && !(busy && exp_q.size() == DEPTH - 1); i++) cycle();
    chk("t5_reached", (busy && exp_q.size() == DEPTH - 1) ? 32'd1 : 32'd0, 32'd1);
    do_reset();
    bus.mem_ack  = 1'b1;
    bus.mem_inst = 32'hBAD0BAD0;
    cycle();
    chk("t5_nreq", req_log.size(), 32'd1);
    chk("t5_first_addr", req_log[0], 32'h0);
    for (int i = 0; i < 10; i++) cycle();

    // PC wrap across the top of the address space
    lat_lo = 1; lat_hi = 3;
    do_reset();
    bus.dec_ready       = 1'b1;
    bus.rob_redirect    = 1'b1;
    bus.rob_redirect_pc = 32'hFFFFFFF8;
    for (int i = 0; i < 60 && req_log.size() < 3; i++) cycle();
    chk("t6_addr0", req_log[0], 32'hFFFFFFF8);
    chk("t6_addr1", req_log[1], 32'hFFFFFFFC);
    chk("t6_wrap", req_log[2], 32'h0);

    // Random decoder backpressure, memory latency and redirects
    lat_lo = 1; lat_hi = 4;
    do_reset();
    d0 = delivered;
    for (int i = 0; i < 3000; i++) begin
      bus.dec_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(99, 0) < 3) begin
        rnd = $urandom;
        bus.rob_redirect    = 1'b1;
        bus.rob_redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFFFFF0 | {28'h0, rnd[3:2], 2'b00})
                                                          : {rnd[31:2], 2'b00};
      end
      cycle();
    end
    chk("t7_progress", (delivered - d0 > 200) ? 32'd1 : 32'd0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
